// File: rtl/sc_uart_tx_port.sv
// sc_uart_tx_port: memory-mapped 8N1 serial transmitter with a byte FIFO on the CPU data bus
module sc_uart_tx_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [4:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d, period_q, period_d, bcnt_q, bcnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, irq_q, irq_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          wr, push, accept, pop, full, empty, busy, bdone;
    logic          unused_bits;

    assign sel         = addr[31:4] == BASE_ADDR[31:4];
    assign wr          = we & sel;
    assign push        = wr & (addr[3:2] == 2'd0);
    assign full        = count_q == 5'(FIFO_DEPTH);
    assign empty       = count_q == 5'd0;
    assign accept      = push & ~full;
    assign busy        = state_q != IDLE;
    assign pop         = ~busy & ~empty;
    assign bdone       = bcnt_q == 16'd0;
    assign tx          = tx_q;
    assign irq         = irq_q;
    assign unused_bits = ^{wdata[31:16], addr[1:0]};
    assign rdata = !sel                ? 32'd0 :
                   addr[3:2] == 2'd1   ? {24'd0, count_q[3:0], ovf_q, busy, full, empty} :
                   addr[3:2] == 2'd2   ? {16'd0, div_q} : 32'd0;

    // FIFO pointers, occupancy, sticky overflow and divisor register updates
    always_comb begin
        wptr_d  = accept ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + {4'd0, accept} - {4'd0, pop};
        ovf_d   = (push & full) | (ovf_q & ~(wr & (addr[3:2] == 2'd1) & wdata[3]));
        div_d   = (wr & (addr[3:2] == 2'd2)) ? (wdata[15:0] == 16'd0 ? 16'd1 : wdata[15:0]) : div_q;
    end

    // Transmit FSM: the line level is computed for the next state so tx can be registered
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        bcnt_d   = bcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        irq_d    = empty & ~busy;
        case (state_q)
            IDLE: if (!empty) begin
                state_d  = START;
                shift_d  = mem_q[rptr_q];
                period_d = div_q;
                bcnt_d   = div_q - 16'd1;
                tx_d     = 1'b0;
            end
            START: if (bdone) begin
                state_d  = DATA;
                bitcnt_d = 3'd0;
                bcnt_d   = period_q - 16'd1;
                tx_d     = shift_q[0];
            end else bcnt_d = bcnt_q - 16'd1;
            DATA: if (bdone) begin
                state_d  = bitcnt_q == 3'd7 ? STOP : DATA;
                shift_d  = {1'b0, shift_q[7:1]};
                bitcnt_d = bitcnt_q + 3'd1;
                bcnt_d   = period_q - 16'd1;
                tx_d     = bitcnt_q == 3'd7 ? 1'b1 : shift_q[1];
            end else bcnt_d = bcnt_q - 16'd1;
            STOP: if (bdone) begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end else bcnt_d = bcnt_q - 16'd1;
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clock) begin
        if (accept) mem_q[wptr_q] <= wdata[7:0];
    end

    // State register; reset abandons any frame in flight and empties the FIFO
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= 5'd0;
            ovf_q    <= 1'b0;
            div_q    <= DIV_DEFAULT;
            period_q <= 16'd0;
            bcnt_q   <= 16'd0;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            period_q <= period_d;
            bcnt_q   <= bcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            irq_q    <= irq_d;
        end
    end
endmodule

// File: tb/tb_sc_uart_tx_port.sv
// tb_sc_uart_tx_port: directed checks of the memory-mapped serial transmitter
module tb_sc_uart_tx_port;
    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic        clock = 1'b0, reset = 1'b1, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
    logic        sel, tx, irq;
    int          n_cmp = 0, n_err = 0, cyc = 0;

    sc_uart_tx_port dut (
        .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .sel(sel), .tx(tx), .irq(irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    task automatic wait_irq(input string tag, input int lim);
        int k = 0;
        while (!irq && k < lim) begin tick(); k++; end
        check(tag, irq, 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] obs_tx, exp_tx;
        logic [9:0]  fr;
        int          nbusy, prev, np, c1, c2, nb, tog;
        int          p [2];
        logic [3:0]  cs [2];
        logic [1:0]  txs, d1;
        logic        found;
        // 1: reset values
        repeat (3) tick();
        check("irq_in_reset", irq, 0);
        reset = 1'b0;
        check("irq_before_edge", irq, 0);
        tick();
        check("irq_after_release", irq, 1);
        peek(BASE + 4);
        check("status_reset", rdata, 32'h1);
        check("tx_idle", tx, 1);
        peek(BASE + 8);
        check("div_reset", rdata, 434);
        peek(BASE + 9);
        check("div_low_addr_bits", rdata, 434);
        // 2: one 0xA5 frame at DIV=4
        store(BASE + 8, 4);
        store(BASE, 32'hA5);
        addr = BASE + 4;
        check("tx_before_pop", tx, 1);
        fr = {1'b1, 8'hA5, 1'b0};
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            obs_tx[k] = tx;
            exp_tx[k] = fr[k / 4];
            nbusy += int'(rdata[2]);
        end
        check("frame_a5", obs_tx, exp_tx);
        check("busy_cycles", nbusy, 40);
        tick();
        tick();
        check("irq_after_frame", irq, 1);
        check("status_after_frame", rdata, 32'h1);
        // 3: FIFO fill, overflow and clear
        store(BASE + 8, 2);
        for (int i = 1; i <= 9; i++) store(BASE, i);
        peek(BASE + 4);
        check("nine_accepted", rdata, 32'h86);
        wait_irq("drain_nine", 400);
        store(BASE + 8, 1000);
        for (int i = 0; i < 10; i++) store(BASE, i);
        peek(BASE + 4);
        check("one_dropped", rdata, 32'h8E);
        store(BASE + 4, 32'h8);
        peek(BASE + 4);
        check("ovf_cleared", rdata, 32'h86);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        peek(BASE + 4);
        check("flush_by_reset", rdata, 32'h1);
        // 4: back-to-back frames behind a filler frame at DIV=3
        store(BASE + 8, 3);
        store(BASE, 32'h55);
        store(BASE, 32'h00);
        store(BASE, 32'hFF);
        peek(BASE + 4);
        check("count_two", rdata[7:4], 2);
        prev = 2; np = 0; txs = 2'b11; d1 = 2'b00;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (np > 0 && cyc == p[np-1] + 3) d1[np-1] = tx;
            if (int'(rdata[7:4]) < prev && np < 2) begin
                p[np] = cyc; txs[np] = tx; cs[np] = rdata[7:4]; np++;
            end
            prev = int'(rdata[7:4]);
        end
        check("pop_events", np, 2);
        check("count_after_pop1", cs[0], 1);
        check("count_after_pop2", cs[1], 0);
        check("start_bits_low", txs, 2'b00);
        check("start_spacing", p[1] - p[0], 31);
        check("first_data_bits", d1, 2'b10);
        wait_irq("drain_b2b", 100);
        // 5: DIV change mid-frame only affects the next frame
        store(BASE + 8, 4);
        store(BASE, 32'h0F);
        store(BASE, 32'hF0);
        c1 = cyc;
        addr = BASE + 4;
        repeat (10) tick();
        store(BASE + 8, 2);
        addr = BASE + 4;
        found = 1'b0; c2 = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (rdata[7:4] == 4'd0) begin found = 1'b1; c2 = cyc; end
        end
        check("second_pop_seen", found, 1);
        check("old_width_kept", c2 - c1, 41);
        nb = 1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!rdata[2]) break;
            nb++;
        end
        check("new_width_used", nb, 20);
        store(BASE + 8, 0);
        peek(BASE + 8);
        check("div_zero_as_one", rdata, 1);
        wait_irq("drain_div", 100);
        // 6: reset mid-frame, address decode
        store(BASE + 8, 4);
        store(BASE, 32'h00);
        repeat (8) tick();
        check("tx_low_mid_data", tx, 0);
        #2 reset = 1'b1;
        #1;
        check("tx_async_reset", tx, 1);
        check("irq_async_reset", irq, 0);
        peek(BASE + 4);
        check("status_in_reset", rdata, 32'h1);
        tick();
        reset = 1'b0;
        tog = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            tog += int'(!tx);
        end
        check("no_retransmit", tog, 0);
        peek(BASE + 16);
        check("sel_above", sel, 0);
        check("rdata_above", rdata, 0);
        peek(BASE - 4);
        check("sel_below", sel, 0);
        check("rdata_below", rdata, 0);
        store(BASE + 16, 32'h77);
        store(BASE - 16, 32'h77);
        store(BASE - 4, 32'h77);
        tick();
        peek(BASE + 4);
        check("no_push_outside", rdata, 32'h1);
        check("tx_quiet_outside", tx, 1);
        store(BASE + 12, 32'hFFFF);
        peek(BASE + 12);
        check("sel_reserved", sel, 1);
        check("reserved_reads_0", rdata, 0);
        peek(BASE + 8);
        check("div_after_reserved", rdata, 434);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sc_uart_tx_port.md
Name: sc_uart_tx_port

Overview:
- Memory-mapped serial transmitter peripheral on the single-cycle CPU data bus (address, store data, write enable, load data).
- Acts as the responder to CPU loads and stores in a 16-byte I/O window.
- Buffers bytes written by the CPU in a small FIFO and shifts them out on `tx` as 8N1 serial frames.
- The top level uses `sel` to mux `rdata` into the CPU's load-data path instead of data memory.

Parameters:
- BASE_ADDR, 32'h0000_FF00: I/O window base. Bits [3:0] are ignored.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of 2, from 2 to 16.
- DIV_DEFAULT, 16'd434: reset value of the baud divisor, in clock cycles per bit.

Ports:
- clock  in  1: single system clock. All state updates on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- addr  in  32: byte address from the CPU ALU output.
- wdata  in  32: CPU store data.
- we  in  1: CPU store enable (wmem). Qualified by `sel`.
- rdata  out  32: load data. Combinational from `addr`. 0 when `sel`=0.
- sel  out  1: combinational. 1 when addr[31:4]==BASE_ADDR[31:4].
- tx  out  1: serial line. Idle high. Registered output.
- irq  out  1: registered. 1 when the FIFO is empty and the transmitter is idle.

Behaviour:
- Register map (offset = addr[3:2]):
  - 0 TXDATA. Write pushes wdata[7:0]. Read returns 0.
  - 1 STATUS. Read returns {24'b0, count[3:0], ovf, busy, full, empty}. Writing 1 to wdata[3] clears ovf; all other bits are read-only.
  - 2 DIV. R/W, bits [15:0]; upper bits read 0. A written value of 0 is stored as 1.
  - 3 reserved. Reads 0, writes are ignored.
  - addr[1:0] are ignored.
- Stores are accepted at the clock edge when we & sel. Reads have zero-cycle latency and have no side effects.
- FIFO push:
  - When not full, the push is accepted and count increments.
  - When full, the byte is dropped and ovf is set (sticky). This holds even if a pop occurs in the same cycle; full is evaluated on pre-edge state.
- FIFO pop: occurs only at the IDLE→START transition.
  - Simultaneous push and pop leaves count unchanged. Both pointers wrap modulo FIFO_DEPTH.
  - A push to an empty FIFO cannot pop in the same cycle; the pop happens no earlier than the next edge.
- Divisor is sampled into an internal bit-period register at the IDLE→START transition. A DIV write never disturbs a frame in flight.
- Transmit FSM, with a bit counter `bitcnt` (0-7) and a baud counter `bcnt` (counts down from div_latched-1; the state advances on bcnt==0):
  - IDLE: tx=1. If !empty: pop into shift register, load bcnt, go to START.
  - START: tx=0 for div cycles, then go to DATA with bitcnt=0.
  - DATA: tx=shift[0] for div cycles, then shift right and increment bitcnt. After bit 7, go to STOP.
  - STOP: tx=1 for div cycles, then go to IDLE.
- Frame length is 10*div cycles, plus 1 IDLE cycle between back-to-back frames.
- busy=1 in every state except IDLE. irq = empty & (state==IDLE), registered.
- Write-to-line latency with an empty FIFO in IDLE:
  - The store lands at edge t.
  - The pop and START happen at edge t+1, and tx falls after edge t+1.
- Reset (at any time, including mid-frame) immediately forces:
  - tx=1, state=IDLE, FIFO empty with pointers at 0, count=0;
  - ovf=0, div=DIV_DEFAULT, shift=0, counters=0;
  - irq=0 during reset; irq becomes 1 at the first edge after reset release.
- The partial frame is abandoned, and nothing is retransmitted after reset.

Test Plan:
1. Reset, then read BASE+4 → rdata=32'h0000_0001 and tx=1. Read BASE+8 → 434. Check irq=1 one clock after reset release.
2. Write DIV=4, then write TXDATA=8'hA5 → starting 1 cycle after the store, tx carries:
   - 0 for 4 cycles (start bit);
   - 1,0,1,0,0,1,0,1 for 4 cycles each (LSB first);
   - 1 for 4 cycles (stop bit).
   busy=1 for 40 cycles. Afterwards irq=1 and empty=1.
3. Write DIV=2, then 9 consecutive TXDATA stores (0x01..0x09) with FIFO_DEPTH=8.
   - Verify the first pop frees one slot, so all 9 are accepted; count never exceeds 8.
   - Repeat with DIV=1000 and 10 stores → exactly 1 byte is dropped, ovf=1.
   - Writing STATUS with bit3=1 → ovf=0.
4. Back-to-back frames, DIV=3, bytes 0x00 and 0xFF:
   - Second start bit begins exactly 31 cycles after the first start bit.
   - Count sequence goes 2→1→0 at each pop.
5. Write DIV during the DATA state of frame 1 → frame 1 keeps the old bit width; frame 2 uses the new width.
   - Write DIV=0 → read back 1.
6. Assert reset mid-DATA → tx=1 asynchronously, STATUS reads 1, and there is no further toggling. Also check:
   - addresses BASE+16 and BASE-4 give sel=0 and rdata=0, and stores to them do not push;
   - a read of BASE+12 returns 0.
